// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 key tracker.
// Build option: PS2_KEY_EXT_EN enables E0 extended-key handling.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_POP,
    F_PARSE
  } fetch_t;

  typedef enum logic [1:0] {
    P_NORM,
    P_BRK,
    P_EXT,
    P_EXTBRK
  } pfx_t;

  typedef struct packed {
    logic       make;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Scan-code FIFO handshake between ps2_keyboard and the tracker.
// Build option: none.
interface ps2_key_tracker_if;

  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;

  modport master (
    output data,
    output ready,
    output overflow,
    input  nextdata_n
  );

  modport slave (
    input  data,
    input  ready,
    input  overflow,
    output nextdata_n
  );

endinterface

// File: rtl/ps2_key_tracker_prefix_fsm.sv
// Set-2 make/break prefix parser; events decode from current state.
// Build option: PS2_KEY_EXT_EN builds the EXT/EXTBRK states.
module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = PS2_BREAK,
  parameter logic [7:0] EXT_CODE   = PS2_EXT
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] code_in,
  input  logic       strobe,
  output key_evt_t   evt
);

  pfx_t st;
  pfx_t nxt;

  // Next state and event decode for the byte being parsed.
  always_comb begin
    nxt      = st;
    evt      = '0;
    evt.code = code_in;
    if (strobe) begin
      unique case (st)
        P_NORM: begin
          unique case (1'b1)
            (code_in == BREAK_CODE): nxt = P_BRK;
`ifdef PS2_KEY_EXT_EN
            (code_in == EXT_CODE):   nxt = P_EXT;
`else
            (code_in == EXT_CODE):   nxt = P_NORM;
`endif
            default:                 evt.make = 1'b1;
          endcase
        end
        P_BRK: begin
          evt.brk = 1'b1;
          nxt     = P_NORM;
        end
`ifdef PS2_KEY_EXT_EN
        P_EXT: begin
          if (code_in == BREAK_CODE) begin
            nxt = P_EXTBRK;
          end else begin
            evt.make = 1'b1;
            evt.ext  = 1'b1;
            nxt      = P_NORM;
          end
        end
        P_EXTBRK: begin
          evt.brk = 1'b1;
          evt.ext = 1'b1;
          nxt     = P_NORM;
        end
`endif
        default: nxt = P_NORM;
      endcase
    end
  end

  // Prefix state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) st <= P_NORM;
    else       st <= nxt;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Drains the PS/2 FIFO and tracks make/break events per key.
// Build option: PS2_KEY_EXT_EN makes key_ext live.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = PS2_BREAK,
  parameter logic [7:0] EXT_CODE   = PS2_EXT
) (
  input  logic                clk,
  input  logic                clrn,
  ps2_key_tracker_if.slave    fifo,
  output logic [7:0]          key_code,
  output logic                key_ext,
  output logic                key_down,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [7:0]          press_count,
  output logic                ovf_seen
);

  fetch_t     fst;
  logic [7:0] byte_r;
  key_evt_t   evt;
  logic       same;
  logic       repeat_hit;

  // Fetch: latch head, pop for one cycle, then parse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fst             <= F_IDLE;
      byte_r          <= 8'h00;
      fifo.nextdata_n <= 1'b1;
    end else begin
      unique case (fst)
        F_IDLE: begin
          if (fifo.ready) begin
            byte_r          <= fifo.data;
            fifo.nextdata_n <= 1'b0;
            fst             <= F_POP;
          end
        end
        F_POP: begin
          fifo.nextdata_n <= 1'b1;
          fst             <= F_PARSE;
        end
        F_PARSE: fst <= F_IDLE;
        default: begin
          fifo.nextdata_n <= 1'b1;
          fst             <= F_IDLE;
        end
      endcase
    end
  end

  ps2_prefix_fsm #(
    .BREAK_CODE (BREAK_CODE),
    .EXT_CODE   (EXT_CODE)
  ) u_prefix (
    .clk     (clk),
    .clrn    (clrn),
    .code_in (byte_r),
    .strobe  (fst == F_PARSE),
    .evt     (evt)
  );

  assign same = ({evt.ext, evt.code} == {key_ext, key_code});
  assign repeat_hit = key_down && same;

  // Key state, pulses, press counter and sticky overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_code      <= 8'h00;
      key_down      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'h00;
      ovf_seen      <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (fifo.overflow) ovf_seen <= 1'b1;
      if (evt.make && !repeat_hit) begin
        key_code    <= evt.code;
        key_down    <= 1'b1;
        press_pulse <= 1'b1;
        press_count <= press_count + 8'd1;
      end
      if (evt.brk) begin
        release_pulse <= 1'b1;
        if (same) key_down <= 1'b0;
      end
    end
  end

`ifdef PS2_KEY_EXT_EN
  // Extended flag follows each accepted new press.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) key_ext <= 1'b0;
    else if (evt.make && !repeat_hit) key_ext <= evt.ext;
  end
`else
  assign key_ext = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized bench for ps2_key_tracker with a FIFO and key model.
// Build option: PS2_KEY_EXT_EN selects the extended-key expectations.
module tb_ps2_key_tracker;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_key_tracker_if ifc ();

  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;
  logic       ovf_seen;

  ps2_key_tracker dut (
    .clk           (clk),
    .clrn          (clrn),
    .fifo          (ifc),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_down      (key_down),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count),
    .ovf_seen      (ovf_seen)
  );

`ifdef PS2_KEY_EXT_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  logic [7:0] q[$];

  logic [7:0] m_code = 0;
  logic       m_ext = 0, m_down = 0;
  logic       m_press = 0, m_rel = 0;
  logic [7:0] m_cnt = 0;
  logic       m_ovf = 0;
  bit         m_brk = 0, m_xt = 0;

  bit         have_parse = 0;
  logic [7:0] parse_byte = 0;
  bit         pend = 0;
  bit         ovf_s = 0;

  int checks = 0, failures = 0;
  int cyc = 0, last_pop = -10;
  int npress = 0, nrel = 0, npop = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_code = 0; m_ext = 0; m_down = 0;
    m_press = 0; m_rel = 0; m_cnt = 0; m_ovf = 0;
    m_brk = 0; m_xt = 0;
    have_parse = 0; pend = 0;
  endfunction

  function automatic void m_event(bit mk, bit e,
                                  logic [7:0] c);
    bit match;
    match = ({e, c} == {m_ext, m_code});
    if (mk) begin
      if (!(m_down && match)) begin
        m_code = c; m_ext = e; m_down = 1;
        m_press = 1; m_cnt = m_cnt + 8'd1;
      end
    end else begin
      m_rel = 1;
      if (match) m_down = 0;
    end
  endfunction

  function automatic void m_step(logic [7:0] b);
    if (!m_brk && b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_brk && !m_xt && b == 8'hE0) begin
      if (EXT_ON) m_xt = 1;
    end else begin
      m_event(!m_brk, m_xt, b);
      m_brk = 0; m_xt = 0;
    end
  endfunction

  // Compare DUT against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!clrn) begin
        m_reset();
        chk("nextdata_n_rst", ifc.nextdata_n, 1);
      end
      chk("key_code", key_code, m_code);
      chk("key_ext", key_ext, m_ext);
      chk("key_down", key_down, m_down);
      chk("press_pulse", press_pulse, m_press);
      chk("release_pulse", release_pulse, m_rel);
      chk("press_count", press_count, m_cnt);
      chk("ovf_seen", ovf_seen, m_ovf);
      if (press_pulse) npress++;
      if (release_pulse) nrel++;
      ovf_s = ifc.overflow;
      pend = 0;
      if (clrn && !ifc.nextdata_n) begin
        pend = 1;
        chk("pop_ready", ifc.ready, 1);
        chk("pop_gap", (cyc - last_pop >= 3), 1);
        last_pop = cyc;
        npop++;
      end
    end
  end

  // FIFO model and key-model advance just after each edge.
  initial begin
    ifc.ready = 0; ifc.data = 0; ifc.overflow = 0;
    forever begin
      @(posedge clk);
      #1;
      m_press = 0; m_rel = 0;
      if (ovf_s && clrn) m_ovf = 1;
      if (have_parse) m_step(parse_byte);
      have_parse = 0;
      if (pend && q.size() != 0) begin
        parse_byte = q.pop_front();
        have_parse = 1;
      end
      pend = 0;
      ifc.ready = (q.size() != 0);
      ifc.data  = ifc.ready ? q[0] : 8'h00;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 4000 && (q.size() != 0 || have_parse)) begin
      tick(1);
      k++;
    end
    if (k >= 4000) chk("drain_timeout", 0, 1);
    tick(3);
  endtask

  task automatic do_reset();
    tick(1);
    clrn = 0;
    q.delete();
    tick(3);
    clrn = 1;
    tick(1);
  endtask

  task automatic clr_cnt();
    npress = 0; nrel = 0; npop = 0;
  endtask

  initial begin
    logic [7:0] pool [6];
    int k;
    pool[0] = 8'h1C; pool[1] = 8'h1B; pool[2] = 8'hF0;
    pool[3] = 8'hE0; pool[4] = 8'h75; pool[5] = 8'h00;

    tick(3);
    clrn = 1;
    tick(2);

    clr_cnt();
    q.push_back(8'h1C); q.push_back(8'hF0); q.push_back(8'h1C);
    drain();
    chk("t1_code", key_code, 8'h1C);
    chk("t1_down", key_down, 0);
    chk("t1_count", press_count, 1);
    chk("t1_npress", npress, 1);
    chk("t1_nrel", nrel, 1);

    clr_cnt();
    repeat (3) q.push_back(8'h1B);
    q.push_back(8'hF0); q.push_back(8'h1B);
    drain();
    chk("t2_code", key_code, 8'h1B);
    chk("t2_down", key_down, 0);
    chk("t2_count", press_count, 2);
    chk("t2_npress", npress, 1);

    clr_cnt();
    q.push_back(8'hE0); q.push_back(8'h75); q.push_back(8'hE0);
    q.push_back(8'hF0); q.push_back(8'h75);
    drain();
    chk("t3_code", key_code, 8'h75);
    chk("t3_ext", key_ext, EXT_ON);
    chk("t3_down", key_down, 0);
    chk("t3_npress", npress, 1);
    chk("t3_nrel", nrel, 1);

    clr_cnt();
    q.push_back(8'h21); q.push_back(8'h22);
    q.push_back(8'h23); q.push_back(8'h24);
    drain();
    chk("t4_npop", npop, 4);
    tick(10);
    chk("t4_idle_pops", npop, 4);

    do_reset();
    clr_cnt();
    for (int i = 0; i < 256; i++)
      q.push_back(i[0] ? 8'h1B : 8'h1C);
    drain();
    chk("t5_wrap", press_count, 8'h00);
    chk("t5_npress", npress, 256);
    chk("t5_ovf_pre", ovf_seen, 0);
    ifc.overflow = 1;
    tick(1);
    ifc.overflow = 0;
    tick(5);
    chk("t5_ovf_sticky", ovf_seen, 1);
    do_reset();
    chk("t5_ovf_clr", ovf_seen, 0);

    q.push_back(8'hF0);
    k = 0;
    while (!have_parse && k < 50) begin
      tick(1);
      k++;
    end
    if (k >= 50) chk("t6_pop_timeout", 0, 1);
    clrn = 0;
    tick(2);
    clrn = 1;
    tick(1);
    chk("t6_count", press_count, 0);
    chk("t6_down", key_down, 0);
    clr_cnt();
    q.push_back(8'h1C);
    drain();
    chk("t6_npress", npress, 1);
    chk("t6_code", key_code, 8'h1C);
    chk("t6_down_after", key_down, 1);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 7);
      if (k < 6) q.push_back(pool[k]);
      else q.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 40) == 0) ifc.overflow = 1;
      tick($urandom_range(1, 5));
      ifc.overflow = 0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
